// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings,
// result-ready and start/stop levels, and the reset-active level.
package div_unit_pkg;

   localparam int DIV_DATA_W = 32;

   // State encodings are shared with execute and must not change.
   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   localparam logic RST_ENABLE           = 1'b1;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between execute (master) and the divider (slave).
interface div_unit_if #(
   parameter int DATA_W = div_unit_pkg::DIV_DATA_W
);

   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   modport master (
      output signed_div_i,
      output opdata1_i,
      output opdata2_i,
      output start_i,
      output annul_i,
      input  result_o,
      input  ready_o
   );

   modport slave (
      input  signed_div_i,
      input  opdata1_i,
      input  opdata2_i,
      input  start_i,
      input  annul_i,
      output result_o,
      output ready_o
   );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Returns {remainder, quotient}; signed mode divides magnitudes and fixes
// the signs of both results at the end.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);

   localparam int                CNT_W    = $clog2(DATA_W) + 1;
   localparam int                WORK_W   = 2 * DATA_W + 1;
   localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DATA_W);

   div_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WORK_W-1:0]      work_q, work_d;
   logic [DATA_W-1:0]      dvsr_q, dvsr_d;
   logic                   neg_quot_q, neg_quot_d;
   logic                   neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0]    result_q, result_d;
   logic                   ready_q, ready_d;

   logic [DATA_W:0]        diff;
   logic                   dvd_neg;
   logic                   dvs_neg;
   logic [DATA_W-1:0]      quot;
   logic [DATA_W-1:0]      rem;

   // Two's-complement negate when en is set, pass-through otherwise.
   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic en);
      return en ? (-v) : v;
   endfunction

   assign dvd_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
   assign dvs_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];

   // Trial subtraction of the divisor from the partial remainder.
   assign diff = work_q[2*DATA_W:DATA_W] - {1'b0, dvsr_q};

   assign quot = cond_neg(work_q[DATA_W-1:0], neg_quot_q);
   assign rem  = cond_neg(work_q[2*DATA_W:DATA_W+1], neg_rem_q);

   // Next-state, iteration step and output values for each FSM state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      dvsr_d     = dvsr_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;
      ready_d    = ready_q;

      case (state_q)
         DIV_FREE: begin
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
            cnt_d    = '0;
            if (bus.start_i == DIV_START && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  state_d = DIV_BY_ZERO;
               end else begin
                  state_d    = DIV_ON;
                  work_d     = {{DATA_W{1'b0}}, cond_neg(bus.opdata1_i, dvd_neg), 1'b0};
                  dvsr_d     = cond_neg(bus.opdata2_i, dvs_neg);
                  neg_quot_d = dvd_neg ^ dvs_neg;
                  neg_rem_d  = dvd_neg;
               end
            end
         end

         DIV_BY_ZERO: begin
            state_d  = DIV_END;
            result_d = '0;
            ready_d  = DIV_RESULT_READY;
         end

         DIV_ON: begin
            if (bus.annul_i) begin
               // Flush or exception: drop the division without a result.
               state_d  = DIV_FREE;
               cnt_d    = '0;
               result_d = '0;
               ready_d  = DIV_RESULT_NOT_READY;
            end else if (cnt_q != CNT_DONE) begin
               if (diff[DATA_W]) begin
                  work_d = {work_q[2*DATA_W-1:0], 1'b0};
               end else begin
                  work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
               end
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               state_d  = DIV_END;
               cnt_d    = '0;
               result_d = {rem, quot};
               ready_d  = DIV_RESULT_READY;
            end
         end

         DIV_END: begin
            // Execute holds start until it has consumed the result.
            if (bus.start_i == DIV_STOP) begin
               state_d  = DIV_FREE;
               result_d = '0;
               ready_d  = DIV_RESULT_NOT_READY;
            end
         end

         default: begin
            state_d = DIV_FREE;
         end
      endcase
   end

   // Control state and registered outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q  <= DIV_FREE;
         cnt_q    <= '0;
         result_q <= '0;
         ready_q  <= DIV_RESULT_NOT_READY;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   // Working register and operand/sign captures; only read while DIV_ON.
   always_ff @(posedge clk) begin
      work_q     <= work_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued when a request
// is issued and compared when ready_o rises.
module tb_div_unit;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [63:0] exp_q [$];

   typedef struct packed {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   div_unit_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: divide magnitudes, then apply quotient/remainder signs.
   function automatic logic [63:0] model(input logic s, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] ma, mb, q, r;
      if (b == 32'h0) return 64'h0;
      ma = (s && a[31]) ? (32'h0 - a) : a;
      mb = (s && b[31]) ? (32'h0 - b) : b;
      q  = ma / mb;
      r  = ma % mb;
      if (s && (a[31] ^ b[31])) q = 32'h0 - q;
      if (s && a[31]) r = 32'h0 - r;
      return {r, q};
   endfunction

   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_result, input logic [63:0] exp);
      @(negedge clk);
      bus.signed_div_i = s;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.annul_i      = 1'b0;
      bus.start_i      = 1'b1;
      if (expect_result) exp_q.push_back(exp);
   endtask

   // lat = index of the edge (0 = first edge after issue) after which ready_o was seen.
   task automatic wait_ready(input int budget, output int lat, output bit timed_out);
      timed_out = 1'b1;
      lat = -1;
      for (int i = 0; i < budget && timed_out; i++) begin
         @(negedge clk);
         if (bus.ready_o === 1'b1) begin
            timed_out = 1'b0;
            lat = i;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
      bus.opdata1_i = 32'h0; bus.opdata2_i = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready_o); end
      checks++;
      if (bus.result_o !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result_o); end
      bus.start_i = 1'b1; bus.opdata1_i = 32'd5; bus.opdata2_i = 32'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_hold_ready got %b want 0", bus.ready_o); end
      bus.start_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      int lat; bit to; logic [63:0] exp;
      issue(1'b0, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);
      wait_ready(60, lat, to);
      checks++;
      if (to || lat != 33) begin errors++; $display("FAIL unsigned_latency got %0d want 33", lat); end
      exp = exp_q.pop_front();
      checks++;
      if (bus.result_o !== exp) begin errors++; $display("FAIL unsigned_result got %h want %h", bus.result_o, exp); end
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
         errors++; $display("FAIL unsigned_hold got %b/%h want 1/%h", bus.ready_o, bus.result_o, exp);
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL unsigned_drop_ready got %b want 0", bus.ready_o); end
      checks++;
      if (bus.result_o !== 64'h0) begin errors++; $display("FAIL unsigned_drop_result got %h want 0", bus.result_o); end
   endtask

   task automatic test_directed();
      vec_t tbl [4];
      int lat; bit to; logic [63:0] exp;
      tbl[0] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
      tbl[1] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
      tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF};
      tbl[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
      for (int i = 0; i < 4; i++) begin
         issue(tbl[i].s, tbl[i].a, tbl[i].b, 1'b1, tbl[i].exp);
         wait_ready(60, lat, to);
         checks++;
         if (to || lat != 33) begin errors++; $display("FAIL directed%0d_latency got %0d want 33", i, lat); end
         exp = exp_q.pop_front();
         checks++;
         if (bus.result_o !== exp) begin errors++; $display("FAIL directed%0d_result got %h want %h", i, bus.result_o, exp); end
         bus.start_i = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL directed%0d_drop got %b want 0", i, bus.ready_o); end
      end
   endtask

   task automatic test_div_zero();
      int lat; bit to; logic [63:0] exp;
      for (int i = 0; i < 2; i++) begin
         issue(i[0], (i == 0) ? 32'h00001234 : 32'h80000000, 32'h0, 1'b1, 64'h0);
         wait_ready(60, lat, to);
         checks++;
         if (to || lat != 1) begin errors++; $display("FAIL divzero%0d_latency got %0d want 1", i, lat); end
         exp = exp_q.pop_front();
         checks++;
         if (bus.result_o !== exp) begin errors++; $display("FAIL divzero%0d_result got %h want %h", i, bus.result_o, exp); end
         bus.start_i = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL divzero%0d_drop got %b want 0", i, bus.ready_o); end
      end
   endtask

   task automatic test_start_drop();
      int lat; bit to; logic [63:0] exp;
      issue(1'b0, 32'hFFFFFFFF, 32'h00000003, 1'b1, 64'h00000000_55555555);
      repeat (5) @(negedge clk);
      bus.start_i = 1'b0;
      wait_ready(60, lat, to);
      checks++;
      if (to || lat != 28) begin errors++; $display("FAIL startdrop_latency got %0d want 28", lat); end
      exp = exp_q.pop_front();
      checks++;
      if (bus.result_o !== exp) begin errors++; $display("FAIL startdrop_result got %h want %h", bus.result_o, exp); end
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         errors++; $display("FAIL startdrop_clear got %b/%h want 0/0", bus.ready_o, bus.result_o);
      end
   endtask

   task automatic test_start_annul();
      int seen = 0;
      @(negedge clk);
      bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
      bus.start_i = 1'b1; bus.annul_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready_o !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL start_annul_ready got %0d cycles high want 0", seen); end
      bus.start_i = 1'b0; bus.annul_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_annul();
      int lat; bit to; int seen = 0; logic [63:0] exp;
      issue(1'b0, 32'd100, 32'd7, 1'b0, 64'h0);
      repeat (10) @(negedge clk);
      bus.annul_i = 1'b1;
      @(negedge clk);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready_o !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL annul_ready got %0d cycles high want 0", seen); end
      issue(1'b0, 32'd9, 32'd3, 1'b1, 64'h00000000_00000003);
      wait_ready(60, lat, to);
      checks++;
      if (to || lat != 33) begin errors++; $display("FAIL annul_next_latency got %0d want 33", lat); end
      exp = exp_q.pop_front();
      checks++;
      if (bus.result_o !== exp) begin errors++; $display("FAIL annul_next_result got %h want %h", bus.result_o, exp); end
      bus.start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_rst_mid();
      int seen = 0;
      issue(1'b1, 32'hFFFFFF00, 32'd5, 1'b0, 64'h0);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         errors++; $display("FAIL rst_mid_outputs got %b/%h want 0/0", bus.ready_o, bus.result_o);
      end
      rst = 1'b0;
      bus.start_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready_o !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rst_mid_ready got %0d cycles high want 0", seen); end
   endtask

   task automatic test_back_to_back();
      int lat; bit to; logic [63:0] exp;
      logic s; logic [31:0] a, b;
      for (int i = 0; i < 6; i++) begin
         s = i[0];
         a = $urandom();
         b = $urandom();
         if (i < 3) b = b >> $urandom_range(4, 28);
         if (b == 32'h0) b = 32'd1;
         issue(s, a, b, 1'b1, model(s, a, b));
         wait_ready(60, lat, to);
         checks++;
         if (to || lat != 33) begin errors++; $display("FAIL b2b%0d_latency got %0d want 33", i, lat); end
         exp = exp_q.pop_front();
         checks++;
         if (bus.result_o !== exp) begin
            errors++; $display("FAIL b2b%0d_result s=%b a=%h b=%h got %h want %h", i, s, a, b, bus.result_o, exp);
         end
         bus.start_i = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_directed();
      test_div_zero();
      test_start_drop();
      test_start_annul();
      test_annul();
      test_rst_mid();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
